// File: rtl/counter_pkg.sv
// Shared constants and a parameter sanity check for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // True when mod_max is a usable top count for a counter of the given width.
  function automatic bit mod_max_fits(input int width, input longint mod_max);
    return (width >= 2) && (width <= 62) && (mod_max >= 1) &&
           (mod_max <= ((longint'(1) << width) - 1));
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle of the up/down counter; master drives controls, slave is the counter.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_down, load, load_val, ovf_clr,
    input  out, tc, ovf
  );

  modport slave (
    input  en, up_down, load, load_val, ovf_clr,
    output out, tc, ovf
  );

endinterface

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE: tick is high on every PRESCALE-th en cycle.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Phase only advances on enabled cycles, so gaps in en stretch the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulus, load, wrap/saturate, tc pulse and sticky ovf.
// Optional en-cycle prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MOD_MAX  = (longint'(1) << WIDTH) - 1,
  parameter int     SAT      = MODE_WRAP,
  parameter int     PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  updown_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

  if (!mod_max_fits(WIDTH, MOD_MAX)) begin : g_bad_mod_max
    $error("updown_counter_param: MOD_MAX does not fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_counter_param: PRESCALE must be at least 1");
  end

  logic             step;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

`ifdef COUNTER_PRESCALE_EN
  logic step_tick;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (step_tick)
  );

  assign step = bus.en && step_tick;
`else
  assign step = bus.en;
`endif

  // Bounds are tested before the +/-1, so a MOD_MAX of all ones never relies on rollover.
  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (bus.load) begin
      out_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else if (step) begin
      if (bus.up_down == DIR_UP) begin
        if (out_q == MAX_V) begin
          out_d = (SAT == MODE_SAT) ? MAX_V : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        if (out_q == '0) begin
          out_d = (SAT == MODE_SAT) ? '0 : MAX_V;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out = out_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule
